pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch stage for the single-issue MIPS core. Holds the architectural PC and issues word fetches to instruction memory over a req/ready handshake. Presents each fetched instruction with its PC+4 to decode, which computes jump targets from PC+4 and the instruction. Accepts one-cycle redirect pulses (jump, jump-register, taken branch) and squashes or discards any wrong-path fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h8000_0180, redirect target on misaligned target (only with ALIGN_CHECK_EN)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; imem_addr held stable while high
- imem_addr  out  32  word fetch address
- imem_ready  in  1  memory completes the fetch this cycle
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- instr_valid  out  1  instr_out/pc_plus4 valid for decode
- instr_ready  in  1  decode accepts this cycle
- instr_out  out  32  fetched instruction
- pc_plus4  out  32  PC of instr_out plus 4 (decode's jump-target base)
- jr_en / jr_addr  in  1 / 32  jump-register redirect
- jump_en / jump_addr  in  1 / 32  J/JAL redirect (target from decode)
- branch_en / branch_addr  in  1 / 32  taken-branch redirect
- addr_err  out  1  one-cycle pulse: misaligned redirect target

## Operation
- FSM: BOOT, FETCH, HOLD.
- BOOT: entered on reset; imem_req=0; moves to FETCH after one cycle.
- FETCH: imem_req=1, imem_addr=pc_q. On imem_ready: if no redirect is pending and no redirect arrives this cycle, capture imem_rdata into instr_out, pc_plus4 <= pc_q+4, move to HOLD. Otherwise discard the data, load pc_q with the target, and stay in FETCH.
- HOLD: instr_valid=1 and outputs held. On instr_valid&&instr_ready: pc_q <= pc_q+4, move to FETCH.
- Redirect priority: jr_en > jump_en > branch_en; a lower-priority redirect in the same cycle is ignored.
- Redirect in HOLD: instr_valid drops next cycle; pc_q <= target; move to FETCH. This applies even if the instruction is accepted in the same cycle.
- Redirect in FETCH while imem_req is outstanding and imem_ready=0: latch the target in pend_q. imem_addr is not changed mid-request. When imem_ready arrives, discard the data, pc_q <= pend_q, and issue a new request.
- A newer redirect overwrites pend_q.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_plus4=RESET_PC+4, addr_err=0; pend_q empty.
- First imem_req: second rising edge after rst_n deasserts.
- Fetch-to-valid latency: instr_valid rises the cycle after imem_ready.
- Minimum cadence: 2 cycles per instruction (FETCH then HOLD with instr_ready=1).
- Redirect-to-request latency: the redirect target appears on imem_addr one cycle after the pulse, or one cycle after imem_ready if pending.
- Reset mid-request: the request is abandoned immediately; memory must tolerate imem_req dropping asynchronously.

## Configuration
- ALIGN_CHECK_EN defined: a redirect target with [1:0]!=0 pulses addr_err for one cycle and redirects to EXC_VECTOR instead of the target.
- ALIGN_CHECK_EN undefined: target[1:0] is forced to 0; addr_err is tied 0.

## Structure
- Shared package: FSM state enum (BOOT/FETCH/HOLD), RESET_PC/EXC_VECTOR defaults, 32-bit word typedef.
- Sub-module next_pc_sel: combinational redirect priority mux producing target and redirect-valid, plus the alignment check under ALIGN_CHECK_EN.

## Test plan
- Reset release with imem_ready=1 always and instr_ready=1 always -> imem_addr sequence 0x0, 0x4, 0x8; pc_plus4 0x4, 0x8, 0xC; one instruction every 2 cycles.
- instr_ready=0 for 5 cycles in HOLD -> instr_out/pc_plus4 stable; no new imem_req; PC advances only after accept.
- jump_en=1, jump_addr=0x0040_0100 pulsed in HOLD -> instr_valid=0 next cycle, then imem_addr=0x0040_0100.
- branch_en pulsed while imem_ready is held low 3 cycles -> imem_addr unchanged until ready; returned data discarded (no instr_valid); next request goes to branch_addr.
- jr_en and jump_en pulsed in the same cycle with different targets -> fetch goes to jr_addr.
- ALIGN_CHECK_EN built, jr_addr=0x0000_1002 -> addr_err pulses for one cycle; next imem_addr=0x8000_0180. Without the macro -> next imem_addr=0x0000_1000, addr_err=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the PC / instruction-fetch stage.
package pc_fetch_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam word_t DEF_RESET_PC   = 32'h0000_0000;
   localparam word_t DEF_EXC_VECTOR = 32'h8000_0180;
   localparam word_t WORD_STEP      = 32'd4;

   // Sequential word address; wraps modulo 2^32.
   function automatic word_t pc_inc(input word_t pc);
      return pc + WORD_STEP;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Redirect priority mux (jr > jump > branch) with optional target alignment check.
// Optional feature macro: ALIGN_CHECK_EN.
module next_pc_sel
   import pc_fetch_unit_pkg::*;
#(
   parameter word_t EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic        jr_en,
   input  logic [31:0] jr_addr,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   input  logic        branch_en,
   input  logic [31:0] branch_addr,
   output logic [31:0] target,
   output logic        redirect,
   output logic        misaligned
);

   word_t raw;

   always_comb begin
      raw      = '0;
      redirect = 1'b0;
      if (jr_en) begin
         raw      = jr_addr;
         redirect = 1'b1;
      end else if (jump_en) begin
         raw      = jump_addr;
         redirect = 1'b1;
      end else if (branch_en) begin
         raw      = branch_addr;
         redirect = 1'b1;
      end
   end

`ifdef ALIGN_CHECK_EN
   assign misaligned = redirect && (raw[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Without the check the low bits are simply dropped to keep fetches word-aligned.
   assign target = misaligned ? EXC_VECTOR : (raw & 32'hFFFF_FFFC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: BOOT/FETCH/HOLD FSM with redirect handling.
// Optional feature macro: ALIGN_CHECK_EN (misaligned targets vector to EXC_VECTOR, pulse addr_err).
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC   = DEF_RESET_PC,
   parameter word_t EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus4,
   input  logic        jr_en,
   input  logic [31:0] jr_addr,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   input  logic        branch_en,
   input  logic [31:0] branch_addr,
   output logic        addr_err
);

   state_t state_q, state_d;
   word_t  pc_q, pc_d;
   word_t  pend_q, pend_d;
   logic   pend_vld_q, pend_vld_d;
   word_t  instr_q, instr_d;
   word_t  pc_plus4_q, pc_plus4_d;
   logic   addr_err_q;

   word_t  target;
   logic   redirect;
   logic   misaligned;

   next_pc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc_sel (
      .jr_en       (jr_en),
      .jr_addr     (jr_addr),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .target      (target),
      .redirect    (redirect),
      .misaligned  (misaligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         instr_q    <= '0;
         pc_plus4_q <= pc_inc(RESET_PC);
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         addr_err_q <= misaligned;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      instr_d     = instr_q;
      pc_plus4_d  = pc_plus4_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         BOOT: begin
            if (redirect) pc_d = target;
            state_d = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               // A redirect arriving with the data is newer than anything pending.
               if (redirect) begin
                  pc_d       = target;
                  pend_vld_d = 1'b0;
               end else if (pend_vld_q) begin
                  pc_d       = pend_q;
                  pend_vld_d = 1'b0;
               end else begin
                  instr_d    = imem_rdata;
                  pc_plus4_d = pc_inc(pc_q);
                  state_d    = HOLD;
               end
            end else if (redirect) begin
               // imem_addr must stay stable until the memory answers.
               pend_d     = target;
               pend_vld_d = 1'b1;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (instr_ready) begin
               pc_d    = pc_inc(pc_q);
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   assign imem_addr = pc_q;
   assign instr_out = instr_q;
   assign pc_plus4  = pc_plus4_q;
   assign addr_err  = addr_err_q;

endmodule
